// File: rtl/johnson_decoder_8bit.sv
// Johnson-code receiver: decodes a Johnson word to its index and monitors sequence integrity and lock.
// Optional build macro JOHNSON_DEC_AUTOCORRECT_EN: single-bit repair of a corrupted successor word.
module johnson_decoder_8bit #(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 3,
    parameter int ERRCNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              code_in,
    input  logic                          code_valid,
    output logic [$clog2(2*WIDTH)-1:0]    index,
    output logic                          index_valid,
    output logic                          illegal,
    output logic                          skip,
    output logic                          restart,
    output logic                          locked,
    output logic [ERRCNT_W-1:0]           err_count
);

    localparam int SEQ_LEN = 2 * WIDTH;
    localparam int IDX_W   = $clog2(SEQ_LEN);
    localparam int RUN_W   = $clog2(LOCK_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_ILLEGAL = 3'd1,
        CLS_CORR    = 3'd2,
        CLS_HOLD    = 3'd3,
        CLS_SUCC    = 3'd4,
        CLS_RESTART = 3'd5,
        CLS_SKIP    = 3'd6
    } cls_e;

    state_e                state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  index_valid_q, index_valid_d;
    logic                  illegal_q, illegal_d;
    logic                  skip_q, skip_d;
    logic                  restart_q, restart_d;
    logic                  locked_q, locked_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

    logic [WIDTH-1:0]      pattern [SEQ_LEN];
    logic [SEQ_LEN-1:0]    match;
    logic                  dec_legal;
    logic [IDX_W-1:0]      dec_idx;
    logic [IDX_W-1:0]      succ_idx;
    logic                  corr_hit;
    logic                  err_event;
    cls_e                  cls;

    // Table of every legal state: k ones from the LSB, then the complements with z zeros from the LSB.
    generate
        for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_pat
            localparam int ONES = (gi <= WIDTH) ? gi : gi - WIDTH;
            localparam logic [WIDTH-1:0] THERM =
                (ONES == 0) ? '0 : ({WIDTH{1'b1}} >> (WIDTH - ONES));
            if (gi <= WIDTH) begin : g_low
                assign pattern[gi] = THERM;
            end else begin : g_high
                assign pattern[gi] = ~THERM;
            end
            assign match[gi] = (code_in == pattern[gi]);
        end
    endgenerate

    assign dec_legal = |match;

    always_comb begin
        dec_idx = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (match[i]) begin
                dec_idx = dec_idx | IDX_W'(i);
            end
        end
    end

    assign succ_idx = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;

`ifdef JOHNSON_DEC_AUTOCORRECT_EN
    logic [WIDTH-1:0] succ_diff;
    assign succ_diff = code_in ^ pattern[succ_idx];
    // End bits must match the successor so the repair never crosses a half-cycle boundary.
    assign corr_hit  = !dec_legal && !succ_diff[WIDTH-1] && !succ_diff[0] &&
                       (succ_diff != '0) && ((succ_diff & (succ_diff - 1'b1)) == '0);
`else
    assign corr_hit  = 1'b0;
`endif

    // Priority order matters: prev index 0 or the last index can never reach the restart branch.
    always_comb begin
        cls = CLS_NONE;
        if (code_valid) begin
            if (!dec_legal) begin
                cls = corr_hit ? CLS_CORR : CLS_ILLEGAL;
            end else if (dec_idx == index_q) begin
                cls = CLS_HOLD;
            end else if (dec_idx == succ_idx) begin
                cls = CLS_SUCC;
            end else if (dec_idx == '0) begin
                cls = CLS_RESTART;
            end else begin
                cls = CLS_SKIP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_HUNT;
            run_q         <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            skip_q        <= 1'b0;
            restart_q     <= 1'b0;
            locked_q      <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            illegal_q     <= illegal_d;
            skip_q        <= skip_d;
            restart_q     <= restart_d;
            locked_q      <= locked_d;
            err_count_q   <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            ST_HUNT: begin
                if (cls == CLS_HOLD || cls == CLS_SUCC || cls == CLS_RESTART || cls == CLS_SKIP) begin
                    state_d = ST_SYNC;
                    run_d   = '0;
                end
            end
            ST_SYNC: begin
                case (cls)
                    CLS_SUCC: begin
                        run_d = run_q + 1'b1;
                        if (run_q + 1'b1 >= LOCK_RUN) begin
                            state_d = ST_LOCKED;
                        end
                    end
                    CLS_RESTART, CLS_SKIP: run_d = '0;
                    CLS_ILLEGAL: begin
                        state_d = ST_HUNT;
                        run_d   = '0;
                    end
                    default: ;
                endcase
            end
            ST_LOCKED: begin
                if (cls == CLS_SKIP || cls == CLS_ILLEGAL) begin
                    state_d = ST_SYNC;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ST_HUNT;
                run_d   = '0;
            end
        endcase
    end

    assign err_event = (cls == CLS_ILLEGAL) || (cls == CLS_SKIP) || (cls == CLS_CORR);

    always_comb begin
        index_d       = index_q;
        index_valid_d = 1'b0;
        illegal_d     = 1'b0;
        skip_d        = 1'b0;
        restart_d     = 1'b0;
        locked_d      = (state_d == ST_LOCKED);
        err_count_d   = err_count_q;
        case (cls)
            CLS_ILLEGAL: illegal_d = 1'b1;
            CLS_CORR: begin
                index_d       = succ_idx;
                index_valid_d = 1'b1;
            end
            CLS_HOLD, CLS_SUCC: begin
                index_d       = dec_idx;
                index_valid_d = 1'b1;
            end
            CLS_RESTART: begin
                index_d       = dec_idx;
                index_valid_d = 1'b1;
                restart_d     = 1'b1;
            end
            CLS_SKIP: begin
                index_d       = dec_idx;
                index_valid_d = 1'b1;
                skip_d        = 1'b1;
            end
            default: ;
        endcase
        if (err_event && (err_count_q != {ERRCNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign illegal     = illegal_q;
    assign skip        = skip_q;
    assign restart     = restart_q;
    assign locked      = locked_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_decoder_8bit.sv
// Scoreboard bench for johnson_decoder_8bit: directed scenarios, random traffic, error saturation.
module tb_johnson_decoder_8bit;

    localparam int W   = 8;
    localparam int SEQ = 2 * W;
    localparam int LOCK_LEN = 3;

    typedef struct packed {
        logic [3:0] idx;
        logic       iv;
        logic       ill;
        logic       skp;
        logic       rst;
        logic       lck;
        logic [7:0] err;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic [3:0] index;
    logic       index_valid, illegal, skip, restart, locked;
    logic [7:0] err_count;

    int   total = 0;
    int   bad = 0;
    int   txn = 0;
    out_t exp_q[$];

    logic [7:0] jseq[SEQ];
    int m_prev, m_state, m_run, m_err;

    johnson_decoder_8bit dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .index(index), .index_valid(index_valid), .illegal(illegal), .skip(skip),
        .restart(restart), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic out_t dut_out();
        out_t o;
        o.idx = index; o.iv = index_valid; o.ill = illegal; o.skp = skip;
        o.rst = restart; o.lck = locked; o.err = err_count;
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got idx=%0d iv=%b ill=%b skip=%b rst=%b lock=%b err=%0d, want idx=%0d iv=%b ill=%b skip=%b rst=%b lock=%b err=%0d",
                     name, got.idx, got.iv, got.ill, got.skp, got.rst, got.lck, got.err,
                     want.idx, want.iv, want.ill, want.skp, want.rst, want.lck, want.err);
        end
    endtask

    function automatic int find_idx(input logic [7:0] c);
        for (int i = 0; i < SEQ; i++) if (jseq[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_state = 0; m_run = 0; m_err = 0;
    endtask

    // Classes: 0 none, 1 illegal, 2 corrected, 3 hold, 4 successor, 5 restart, 6 skip.
    task automatic model_step(input logic v, input logic [7:0] c, output out_t e);
        int k, nxt, cls;
        logic [7:0] diff;
        nxt = (m_prev + 1) % SEQ;
        k = find_idx(c);
        cls = 0;
        diff = c ^ jseq[nxt];
        if (v) begin
            if (k < 0) begin
                cls = 1;
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
                if ($countones(diff) == 1 && !diff[7] && !diff[0]) cls = 2;
`endif
            end else if (k == m_prev) cls = 3;
            else if (k == nxt) cls = 4;
            else if (k == 0) cls = 5;
            else cls = 6;
        end
        case (m_state)
            0: if (cls >= 3) begin m_state = 1; m_run = 0; end
            1: begin
                if (cls == 4) begin
                    m_run++;
                    if (m_run >= LOCK_LEN) m_state = 2;
                end else if (cls == 5 || cls == 6) m_run = 0;
                else if (cls == 1) begin m_state = 0; m_run = 0; end
            end
            default: if (cls == 6 || cls == 1) begin m_state = 1; m_run = 0; end
        endcase
        if ((cls == 1 || cls == 2 || cls == 6) && m_err < 255) m_err++;
        if (cls == 2) m_prev = nxt;
        else if (cls >= 3) m_prev = k;
        e.idx = 4'(m_prev);
        e.iv  = (cls >= 2);
        e.ill = (cls == 1);
        e.skp = (cls == 6);
        e.rst = (cls == 5);
        e.lck = (m_state == 2);
        e.err = 8'(m_err);
    endtask

    task automatic drive(input logic v, input logic [7:0] c);
        out_t e;
        @(negedge clk);
        code_valid = v;
        code_in = c;
        model_step(v, c, e);
        exp_q.push_back(e);
    endtask

    task automatic step_idx(input int k);
        drive(1'b1, jseq[k]);
    endtask

    // Monitor: every registered output update after a driven cycle is popped and compared.
    initial begin
        out_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_out();
                txn++;
                check($sformatf("txn%0d", txn), g, e);
                $display("txn %0d code=%b valid=%b idx=%0d iv=%b ill=%b skip=%b rst=%b lock=%b err=%0d",
                         txn, code_in, code_valid, g.idx, g.iv, g.ill, g.skp, g.rst, g.lck, g.err);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t zero;
        out_t o;
        int r, k, budget;
        zero = '0;
        jseq[0] = 8'h00;
        for (int i = 1; i < SEQ; i++) jseq[i] = {jseq[i-1][6:0], ~jseq[i-1][7]};
        model_reset();

        #2 reset = 1'b0;
        #1 check("reset_state", dut_out(), zero);
        #7 reset = 1'b1;

        // Full cycle 0..15 then wrap to 0; lock after the third successor.
        for (int i = 0; i < SEQ; i++) step_idx(i);
        step_idx(0);
        // Restart from index 9 while locked.
        for (int i = 1; i <= 9; i++) step_idx(i);
        step_idx(0);
        // Skip from index 4 to 6.
        for (int i = 1; i <= 4; i++) step_idx(i);
        step_idx(6);
        // Illegal word, then recover into sync and relock.
        drive(1'b1, 8'b0101_0101);
        for (int i = 7; i < SEQ; i++) step_idx(i);
        for (int i = 0; i <= 3; i++) step_idx(i);
        // Hold index 3 for five cycles while locked.
        for (int i = 0; i < 5; i++) step_idx(3);
        drive(1'b0, 8'h00);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        o = dut_out();
        check("async_reset", o, zero);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60) step_idx((m_prev + 1) % SEQ);
            else if (r < 70) step_idx(m_prev);
            else if (r < 78) begin
                k = $urandom_range(0, SEQ - 1);
                step_idx(k);
            end else if (r < 88) drive(1'b1, 8'($urandom));
            else drive(1'b0, 8'($urandom));
        end

        // Error counter saturation.
        for (int n = 0; n < 300; n++) drive(1'b1, (n % 2 == 0) ? 8'b0101_0101 : 8'b1010_1010);
        drive(1'b0, 8'h00);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        total++;
        if (err_count !== 8'd255) begin
            bad++;
            $display("FAIL err_saturate: got %0d want 255", err_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_decoder_8bit.md
Name: johnson_decoder_8bit

Overview:
Receive-side companion to the 8-bit Johnson counter. Samples a Johnson-coded word on each qualified clock and decodes it to a binary index 0..15. Checks that the code is legal and that successive samples follow the counter sequence, and tracks sequence lock. Sits downstream of the counter (or any Johnson-coded source) as a decoder and integrity monitor.

Parameters:
WIDTH, 8, Johnson word width; sequence length is 2*WIDTH; WIDTH must be even and at least 4.
LOCK_LEN, 3, number of consecutive correct successor samples needed to declare lock.
ERRCNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
code_in  input  WIDTH  Johnson-coded word from the counter.
code_valid  input  1  qualifies code_in for this cycle.
index  output  $clog2(2*WIDTH) (4)  decoded binary index of the last legal sample.
index_valid  output  1  one-cycle pulse: index updated from a legal sample.
illegal  output  1  one-cycle pulse: sampled word is not a Johnson state.
skip  output  1  one-cycle pulse: legal word but not hold, successor or restart.
restart  output  1  one-cycle pulse: legal index 0 received from a nonzero previous index.
locked  output  1  level: sequence lock achieved.
err_count  output  ERRCNT_W  saturating count of illegal plus skip events.

Behaviour:
- Sequence definition (shift-left, inverted MSB into LSB):
  - 00000000 -> 00000001 -> 00000011 -> ... -> 11111111 -> 11111110 -> ... -> 10000000 -> 00000000.
  - Index k, 0..WIDTH: k contiguous ones from the LSB, zeros above.
  - Index WIDTH+z, z = 1..WIDTH-1: z contiguous zeros from the LSB, ones above.
  - Any other pattern is illegal.
- Latency: all outputs are registered, 1 cycle after the code_valid sample. With code_valid low, all pulses are 0 and all state holds.
- Reset (asynchronous, reset = 0):
  - index = 0; all pulses = 0; locked = 0; err_count = 0; FSM = HUNT; prev_idx = 0; run count = 0.
  - Reset mid-stream discards all history.
- Classification of a valid sample, given prev_idx:
  - illegal: pattern fails the legality rule. index and prev_idx are held.
  - hold: decoded index == prev_idx. Not an error, does not advance the run count, index_valid = 1.
  - successor: decoded index == (prev_idx + 1) mod 2*WIDTH. Wrap from 15 to 0 is a successor, not a restart.
  - restart: decoded index == 0 and prev_idx is not 0 or 15. Not an error. restart = 1.
  - skip: any other legal index.
  - For every legal sample: index and prev_idx take the decoded value and index_valid = 1.
- FSM:
  - HUNT: first legal sample -> SYNC, run count = 0. Illegal stays in HUNT and is counted as an error.
  - SYNC:
    - successor increments the run count; at LOCK_LEN -> LOCKED, and locked rises in the same output cycle.
    - hold keeps the current state.
    - restart sets run count = 0 and stays in SYNC.
    - skip sets run count = 0 and stays in SYNC.
    - illegal -> HUNT.
  - LOCKED:
    - successor, hold and restart stay LOCKED.
    - restart does not drop lock.
    - skip or illegal -> SYNC, run count = 0, and locked falls in the same output cycle.
- Error counter:
  - Increments by 1 on each illegal or skip event.
  - Saturates at 2^ERRCNT_W - 1; no wrap.
  - Only one increment per cycle is possible, since illegal and skip are exclusive.
- Simultaneous conditions: the classification order is illegal, then hold, then successor, then restart, then skip. Exactly one class applies per sample.

Optional Feature:
Macro JOHNSON_DEC_AUTOCORRECT_EN.
- Defined: an illegal word whose MSB and LSB agree with the expected successor, and which differs from the successor in exactly one bit, is treated as that successor. index advances, index_valid = 1, illegal = 0, and err_count still increments. FSM state is unaffected.
- Undefined: every illegal word is handled exactly as in Behaviour.

Test Plan:
- Reset low at t=2, released at t=10, then 16 valid Johnson steps from 00000000 -> index 0,1,...,15, then 0. locked = 1 after the 3rd successor (index 3 sample). illegal, skip and err_count all stay 0.
- Locked at index 9 (11111110 ... wait index 9 = 11111110), inject 00000000 -> restart = 1, skip = 0, locked stays 1, index = 0.
- Locked at index 4 (00001111), inject 00111111 (index 6) -> skip = 1, locked = 0, err_count = 1, index = 6.
- Inject 01010101 -> illegal = 1, index holds its prior value, FSM returns to HUNT, err_count increments. The next legal word re-enters SYNC.
- Hold 00000111 for 5 valid cycles while locked -> index_valid pulses each cycle, index = 3, no error.
- Assert reset = 0 asynchronously mid-cycle while locked with err_count = 2 -> all outputs are 0 immediately, with no clock edge required.
- Drive 300 alternating illegal words -> err_count saturates at 255 and does not wrap.
